// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures one byte per rising edge of the completion flag and drops error
// frames while counting them. Bytes leave through a first-word-fall-through
// valid/ready port. Sticky overflow flag and a saturating error counter are
// cleared by i_clr_flags.
module uart_rx_fifo #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           i_rx_d,
    input  logic                 i_rx_complete,
    input  logic                 i_rx_error,
    input  logic                 i_rd_ready,
    input  logic                 i_clr_flags,
    output logic                 o_rd_valid,
    output logic [7:0]           o_rd_data,
    output logic [ADDR_W:0]      o_level,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_overflow,
    output logic [ERR_CNT_W-1:0] o_err_cnt
);

    localparam int unsigned     DEPTH      = 1 << ADDR_W;
    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

    logic [7:0]           mem_q [DEPTH];

    logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]      level_q, level_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 valid_q, valid_d;
    logic                 overflow_q, overflow_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 complete_q, complete_d;

    logic cap;
    logic push;
    logic pop;
    logic push_ok;
    logic wr_en;

    // Next-state logic: edge detect, push/pop arbitration, level and flags
    always_comb begin
        cap     = i_rx_complete & ~complete_q;
        push    = cap & ~i_rx_error;
        pop     = valid_q & i_rd_ready;
        // A pop in the same cycle frees the slot the push needs when full
        push_ok = push & (~full_q | pop);
        wr_en   = rst_n & push_ok;

        complete_d = i_rx_complete;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        if (push_ok && !pop) begin
            level_d = level_q + (ADDR_W + 1)'(1);
        end else if (!push_ok && pop) begin
            level_d = level_q - (ADDR_W + 1)'(1);
        end

        full_d  = (level_d == FULL_LEVEL);
        empty_d = (level_d == '0);
        valid_d = (level_d != '0);

        // Clear first so a coincident overflow/error event takes precedence
        if (i_clr_flags) begin
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end
        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (cap && i_rx_error && (err_cnt_d != '1)) begin
            err_cnt_d = err_cnt_d + ERR_CNT_W'(1);
        end
    end

    // Control and status registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            valid_q    <= 1'b0;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
            complete_q <= 1'b1;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            valid_q    <= valid_d;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
            complete_q <= complete_d;
        end
    end

    // Storage array, not reset; writes are blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= i_rx_d;
        end
    end

    assign o_rd_valid = valid_q;
    assign o_rd_data  = mem_q[rd_ptr_q];
    assign o_level    = level_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_overflow = overflow_q;
    assign o_err_cnt  = err_cnt_q;

endmodule
